// File: rtl/sha256_core_standard_control_if.sv
// Upstream request/digest handshake of the SHA-256 compression control FSM.
// The requester drives start/first_block_in/abort/digest_ack; the core answers with status.
interface sha256_core_standard_control_if;
  logic start;
  logic first_block_in;
  logic abort;
  logic digest_ack;
  logic ready;
  logic digest_valid;
  logic error;

  modport master (
    output start, first_block_in, abort, digest_ack,
    input  ready, digest_valid, error
  );

  modport slave (
    input  start, first_block_in, abort, digest_ack,
    output ready, digest_valid, error
  );
endinterface

// File: rtl/sha256_core_standard_control.sv
// Sequencing FSM for the standard SHA-256 compression datapath: accepts a block,
// strobes the datapath through 64 rounds, then holds the digest until acknowledged.
module sha256_core_standard_control #(
  parameter int unsigned                 ROUND_CNT_W      = 6,
  parameter logic [ROUND_CNT_W-1:0]      SHA256_LOOP_LAST = 6'd63
) (
  input  logic                           clk,
  input  logic                           reset_n,
  sha256_core_standard_control_if.slave  ctrl,
  input  logic                           t_ctr_last,
  output logic                           first_block,
  output logic                           t_ctr_init,
  output logic                           t_ctr_next,
  output logic                           w_init,
  output logic                           w_next,
  output logic                           digest_init,
  output logic                           loop_init,
  output logic                           loop_next
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ROUND_CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic                   first_block_q, first_block_d;
  logic                   error_q, error_d;

  logic ready_c;
  logic accept_c;
  logic init_c;
  logic next_c;
  logic t_next_c;

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      round_cnt_q   <= '0;
      first_block_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_cnt_q   <= round_cnt_d;
      first_block_q <= first_block_d;
      error_q       <= error_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    round_cnt_d   = round_cnt_q;
    first_block_d = first_block_q;
    error_d       = error_q;
    init_c        = 1'b0;
    next_c        = 1'b0;
    t_next_c      = 1'b0;

    ready_c  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    accept_c = reset_n && ready_c && ctrl.start && !ctrl.abort;

    if (accept_c) begin
      // Accepting in DONE doubles as the digest acknowledge (chaining).
      init_c        = 1'b1;
      state_d       = ST_ROUNDS;
      round_cnt_d   = '0;
      error_d       = 1'b0;
      first_block_d = ctrl.first_block_in;
    end else begin
      unique case (state_q)
        ST_ROUNDS: begin
          if (ctrl.abort) begin
            state_d = ST_IDLE;
          end else if (t_ctr_last != (round_cnt_q == SHA256_LOOP_LAST)) begin
            // Datapath and local round count disagree: the block is garbage.
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            next_c      = 1'b1;
            t_next_c    = !t_ctr_last;
            round_cnt_d = round_cnt_q + 1'b1;
            if (t_ctr_last) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (ctrl.abort || ctrl.digest_ack) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign ctrl.ready        = ready_c;
  assign ctrl.digest_valid = (state_q == ST_DONE);
  assign ctrl.error        = error_q;

  assign first_block = accept_c ? ctrl.first_block_in : first_block_q;
  assign t_ctr_init  = init_c;
  assign w_init      = init_c;
  assign loop_init   = init_c;
  assign digest_init = init_c;
  assign t_ctr_next  = t_next_c;
  assign w_next      = next_c;
  assign loop_next   = next_c;

endmodule

// File: tb/tb_sha256_core_standard_control.sv
// Directed bench for the SHA-256 control FSM, with a behavioural datapath round
// counter that produces t_ctr_last from the init/next strobes.
module tb_sha256_core_standard_control;

  logic clk;
  logic reset_n;
  logic t_ctr_last;
  logic first_block;
  logic t_ctr_init, t_ctr_next, w_init, w_next, digest_init, loop_init, loop_next;

  sha256_core_standard_control_if bus ();

  sha256_core_standard_control dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl        (bus.slave),
    .t_ctr_last  (t_ctr_last),
    .first_block (first_block),
    .t_ctr_init  (t_ctr_init),
    .t_ctr_next  (t_ctr_next),
    .w_init      (w_init),
    .w_next      (w_next),
    .digest_init (digest_init),
    .loop_init   (loop_init),
    .loop_next   (loop_next)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Datapath t_ctr stand-in: init clears, next increments, last flags 63.
  logic [5:0] tctr;
  logic       force_last;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        tctr <= '0;
    else if (t_ctr_init) tctr <= '0;
    else if (t_ctr_next) tctr <= tctr + 6'd1;
  end
  assign t_ctr_last = (tctr == 6'd63) || force_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected order: 4 init strobes, t_ctr_next, w_next, loop_next,
  // ready, digest_valid, error, first_block.
  function automatic logic [10:0] obs();
    return {t_ctr_init, w_init, loop_init, digest_init, t_ctr_next, w_next, loop_next,
            bus.ready, bus.digest_valid, bus.error, first_block};
  endfunction

  function automatic logic [10:0] ev(input logic init, input logic tn, input logic nx,
                                     input logic rdy, input logic dv, input logic er,
                                     input logic fb);
    return {init, init, init, init, tn, nx, nx, rdy, dv, er, fb};
  endfunction

  task automatic idle_inputs();
    bus.start          = 1'b0;
    bus.first_block_in = 1'b0;
    bus.abort          = 1'b0;
    bus.digest_ack     = 1'b0;
    force_last         = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    reset_n = 1'b0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.start          = (c < 3);
      bus.first_block_in = 1'b1;
      if (c == 3) reset_n = 1'b1;
      #1;
      e = ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  // Single block with first_block_in=1, digest held 10 cycles, then ack.
  task automatic test_single_block(input string name);
    logic [10:0] e;
    for (int c = 0; c <= 76; c++) begin
      @(negedge clk);
      idle_inputs();
      bus.start          = (c == 0);
      bus.first_block_in = (c == 0);
      bus.digest_ack     = (c == 75);
      #1;
      e = ev(c == 0, c >= 1 && c <= 63, c >= 1 && c <= 64, c == 0 || c >= 65,
             c >= 65 && c <= 75, 1'b0, 1'b1);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL %s cyc %0d: got %b want %b", name, c, obs(), e);
      end
    end
  endtask

  // Chain a second block (first_block_in=0) in the first DONE cycle with ack
  // also high, then abort out of the second DONE.
  task automatic test_chain();
    logic [10:0] e;
    for (int c = 0; c <= 131; c++) begin
      @(negedge clk);
      idle_inputs();
      bus.start          = (c == 0) || (c == 65);
      bus.first_block_in = (c == 0);
      bus.digest_ack     = (c == 65);
      bus.abort          = (c == 130);
      #1;
      e = ev(c == 0 || c == 65,
             (c >= 1 && c <= 63) || (c >= 66 && c <= 128),
             (c >= 1 && c <= 64) || (c >= 66 && c <= 129),
             c == 0 || c == 65 || c >= 130,
             c == 65 || c == 130, 1'b0, c < 65);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL chain cyc %0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  // Abort in ROUNDS cycle 20, then start+abort in IDLE must be ignored.
  task automatic test_abort();
    logic [10:0] e;
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      idle_inputs();
      bus.start          = (c == 0) || (c == 25);
      bus.first_block_in = (c == 0);
      bus.abort          = (c == 20) || (c == 25);
      #1;
      e = ev(c == 0, c >= 1 && c <= 19, c >= 1 && c <= 19, c == 0 || c >= 21,
             1'b0, 1'b0, 1'b1);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL abort cyc %0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  // t_ctr_last forced high at round 10; error sticks until the next accept.
  task automatic test_watchdog();
    logic [10:0] e;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      idle_inputs();
      bus.start          = (c == 0) || (c == 14);
      bus.first_block_in = (c == 14);
      bus.abort          = (c == 16);
      force_last         = (c == 11);
      #1;
      e = ev(c == 0 || c == 14,
             (c >= 1 && c <= 10) || c == 15,
             (c >= 1 && c <= 10) || c == 15,
             c == 0 || (c >= 12 && c <= 14) || c >= 17,
             1'b0, c >= 12 && c <= 14, c >= 14);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL watchdog cyc %0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  // Reset pulsed at round 30, then a fresh block must behave normally.
  task automatic test_reset_mid_rounds();
    logic [10:0] e;
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      idle_inputs();
      bus.start = (c == 0);
      if (c == 31) reset_n = 1'b0;
      #1;
      if (c < 31) e = ev(c == 0, c >= 1, c >= 1, c == 0, 1'b0, 1'b0, 1'b0);
      else        e = ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d: got %b want %b", c, obs(), e);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    test_single_block("post_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_block("single");
    test_chain();
    test_abort();
    test_watchdog();
    test_reset_mid_rounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha256_core_standard_control.md
Name: sha256_core_standard_control

Overview:
- Control FSM for the standard SHA-256 compression datapath. It is the sequencing end of that datapath's strobe interface.
- Accepts one 512-bit block request per start handshake and drives the datapath strobes (t_ctr_init/next, w_init/next, loop_init/next, digest_init, first_block).
- Runs exactly 64 rounds, using the datapath's t_ctr_last as the end marker.
- Presents a ready / digest_valid / digest_ack handshake upstream. Includes an abort input and a round-count watchdog.

Parameters:
- SHA256_LOOP_LAST, 6'd63, index of the final round; the watchdog compares its internal round counter against this.
- ROUND_CNT_W, 6, width of the internal round counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request: block_in/first_block_in valid this cycle
- first_block_in  input  1  1 = use H0 constants, 0 = use prev_digest
- abort  input  1  synchronous cancel of the current operation
- digest_ack  input  1  upstream has consumed the digest
- t_ctr_last  input  1  from datapath, high when datapath t_ctr == 63
- ready  output  1  able to accept start
- digest_valid  output  1  datapath digest_0..7 outputs hold the final result
- error  output  1  sticky watchdog/protocol fault flag
- first_block  output  1  to datapath
- t_ctr_init, t_ctr_next, w_init, w_next, digest_init, loop_init, loop_next  output  1 each  datapath strobes

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset_n is asynchronous, active-low. When low: state=IDLE, round counter=0, first_block_reg=0, error=0.
  - While reset_n is low, all strobes and digest_valid are forced 0. ready=1 (IDLE).
- States: IDLE, ROUNDS, DONE. ready = (IDLE or DONE). digest_valid = DONE.
- Accept condition:
  - accept = reset_n & ready & start & !abort.
  - When accept is high in a cycle, combinationally assert t_ctr_init, w_init, loop_init and digest_init that same cycle (Mealy), so the datapath samples block_in and first_block on the same edge as start.
  - first_block = accept ? first_block_in : first_block_reg. first_block_reg captures first_block_in on accept.
- Transitions:
  - IDLE: accept -> ROUNDS, round counter <= 0, error <= 0.
  - ROUNDS, every cycle (unless aborting):
    - Assert loop_next and w_next.
    - Assert t_ctr_next only when t_ctr_last=0, so the datapath counter parks at 63 rather than wrapping.
    - Round counter increments.
  - ROUNDS end: t_ctr_last=1 with round counter == SHA256_LOOP_LAST -> DONE.
  - DONE: digest_valid held high until digest_ack=1 -> IDLE. An accept in DONE (chaining) is an implicit ack: go directly to ROUNDS with init strobes asserted that cycle. If start and digest_ack are both high, start wins (chain).
- Latency and throughput:
  - start accepted in cycle 0; ROUNDS occupies cycles 1..64 (datapath t_ctr 0..63); digest_valid first high in cycle 65.
  - Back-to-back chained blocks: one accept every 65 cycles.
- Abort:
  - abort=1 in ROUNDS: all strobes 0 that cycle, next state IDLE, digest_valid stays 0.
  - abort=1 in DONE: next state IDLE, digest_valid drops.
  - abort=1 in IDLE: no effect.
  - abort overrides start in the same cycle.
- Watchdog, in ROUNDS:
  - t_ctr_last=1 while round counter != SHA256_LOOP_LAST, or round counter == SHA256_LOOP_LAST while t_ctr_last=0 -> error <= 1, next state IDLE, no strobes that cycle.
  - error is sticky; cleared only by reset or the next accept.
- Strobe exclusivity: init strobes are never high in the same cycle as next strobes. No strobe toggles outside accept or ROUNDS.

Test Plan:
1. Reset release, start=1 with first_block_in=1 at cycle 0 -> t_ctr_init/w_init/loop_init/digest_init high only in cycle 0; first_block=1; loop_next high in cycles 1..64; t_ctr_next high in cycles 1..63; digest_valid rises in cycle 65. With block "abc" padded, datapath digest_0 = 32'hba7816bf.
2. digest_valid held for 10 cycles, then digest_ack -> IDLE next cycle; ready stays 1 throughout; digest_valid falls.
3. Chaining: start with first_block_in=0 in the first DONE cycle -> first_block=0 and init strobes that cycle; second digest_valid rises 65 cycles later. Two-block 448-bit NIST message gives digest_0 = 32'h248d6a61.
4. abort at ROUNDS cycle 20 -> no strobes that cycle; state IDLE; digest_valid never asserts. start with abort=1 in IDLE -> ignored, no init strobes.
5. Forced t_ctr_last=1 at round 10 -> error=1 next cycle; IDLE; no digest_valid. Next accept clears error.
6. reset_n pulsed low mid-ROUNDS (round 30) -> all strobes 0 immediately; IDLE; error=0; a subsequent start behaves as in scenario 1.
